// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA in the clk domain and deserializes
// each stereo frame into {left, right}, delivered as a single-cycle write strobe.
module i2s_receiver #(
    parameter int DATA_BITS   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_bclk,
    input  logic                     i_lrclk,
    input  logic                     i_sdata,
    input  logic                     i_full,
    input  logic                     i_clear_errors,
    output logic [2*DATA_BITS-1:0]   o_frame_out,
    output logic                     o_frame_valid,
    output logic                     o_aligned,
    output logic                     o_overflow,
    output logic                     o_slot_error
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrclk_sync;
    logic [SYNC_STAGES-1:0] r_sdata_sync;
    logic                   r_bclk_d;

    logic                   r_lr_prev;
    logic                   r_aligned;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_BITS-2:0]   r_shift;
    logic [DATA_BITS-1:0]   r_left_hold;
    logic                   r_left_ok;
    logic [2*DATA_BITS-1:0] r_frame;
    logic                   r_pend;
    logic                   r_overflow;
    logic                   r_slot_error;

    logic                   w_bclk_s;
    logic                   w_lrclk_s;
    logic                   w_sdata_s;
    logic                   w_rise;
    logic                   w_act;
    logic                   w_slot_start;
    logic                   w_capture;
    logic                   w_last_bit;
    logic                   w_short;
    logic                   w_emit;
    logic                   w_write;
    logic [DATA_BITS-1:0]   w_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_sdata_sync <= '0;
            r_bclk_d     <= 1'b0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
            r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], i_lrclk};
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i_sdata};
            r_bclk_d     <= w_bclk_s;
        end
    end

    assign w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrclk_s    = r_lrclk_sync[SYNC_STAGES-1];
    assign w_sdata_s    = r_sdata_sync[SYNC_STAGES-1];
    assign w_rise       = w_bclk_s & ~r_bclk_d;
    assign w_act        = i_enable & w_rise;

    // A change of LRCLK marks the delay bit of a new slot; it carries no data.
    assign w_slot_start = w_lrclk_s != r_lr_prev;
    assign w_capture    = ~w_slot_start & r_aligned & (r_bit_cnt < FULL_CNT);
    assign w_last_bit   = w_capture & (r_bit_cnt == LAST_CNT);
    assign w_word       = {r_shift, w_sdata_s};
    assign w_short      = w_act & w_slot_start & r_aligned & (r_bit_cnt < FULL_CNT);
    assign w_emit       = w_act & w_last_bit & w_lrclk_s & r_left_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lr_prev   <= 1'b0;
            r_aligned   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            r_frame     <= '0;
            r_pend      <= 1'b0;
        end else if (!i_enable) begin
            r_lr_prev   <= 1'b0;
            r_aligned   <= 1'b0;
            r_bit_cnt   <= '0;
            r_left_ok   <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            r_pend <= w_emit;
            if (w_rise) begin
                r_lr_prev <= w_lrclk_s;
                if (w_slot_start) begin
                    if (w_short) begin
                        r_left_ok <= 1'b0;
                    end
                    r_bit_cnt <= '0;
                    if (!w_lrclk_s) begin
                        r_aligned <= 1'b1;
                    end
                end else if (w_capture) begin
                    r_shift   <= w_word[DATA_BITS-2:0];
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        if (!w_lrclk_s) begin
                            r_left_hold <= w_word;
                            r_left_ok   <= 1'b1;
                        end else if (r_left_ok) begin
                            r_frame   <= {r_left_hold, w_word};
                            r_left_ok <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // The frame register is always refreshed; only the strobe is withheld when full.
    assign w_write = r_pend & i_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_slot_error <= 1'b0;
        end else begin
            if (w_write & i_full) begin
                r_overflow <= 1'b1;
            end else if (i_clear_errors) begin
                r_overflow <= 1'b0;
            end
            if (w_short) begin
                r_slot_error <= 1'b1;
            end else if (i_clear_errors) begin
                r_slot_error <= 1'b0;
            end
        end
    end

    assign o_frame_out   = r_frame;
    assign o_frame_valid = w_write & ~i_full;
    assign o_aligned     = r_aligned;
    assign o_overflow    = r_overflow;
    assign o_slot_error  = r_slot_error;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives transmitter-format I2S slots and checks the DUT against
// a slot-level model of which stereo pairs must become frames and which flags must be set.
module tb_i2s_receiver;

    localparam int DB = 24;
    localparam int FW = 2 * DB;

    logic          clk;
    logic          reset;
    logic          i_enable;
    logic          i_bclk;
    logic          i_lrclk;
    logic          i_sdata;
    logic          i_full;
    logic          i_clear_errors;
    logic [FW-1:0] o_frame_out;
    logic          o_frame_valid;
    logic          o_aligned;
    logic          o_overflow;
    logic          o_slot_error;

    i2s_receiver #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_bclk         (i_bclk),
        .i_lrclk        (i_lrclk),
        .i_sdata        (i_sdata),
        .i_full         (i_full),
        .i_clear_errors (i_clear_errors),
        .o_frame_out    (o_frame_out),
        .o_frame_valid  (o_frame_valid),
        .o_aligned      (o_aligned),
        .o_overflow     (o_overflow),
        .o_slot_error   (o_slot_error)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    int            checks   = 0;
    int            failures = 0;
    logic [FW-1:0] exp_q[$];
    int            strobe_cyc[$];
    int            cyc        = 0;
    logic          prev_valid = 1'b0;
    int            half       = 25;

    // Slot-level model state
    logic          m_prev;
    logic          m_aligned;
    logic          m_left_ok;
    logic          m_serr;
    logic          m_ovf;
    logic          m_full;
    int            m_cnt;
    logic [DB-1:0] m_left;
    logic [FW-1:0] m_last;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev    = 1'b0;
        m_aligned = 1'b0;
        m_left_ok = 1'b0;
        m_serr    = 1'b0;
        m_ovf     = 1'b0;
        m_full    = 1'b0;
        m_cnt     = 0;
        m_left    = '0;
        m_last    = '0;
    endtask

    // One slot = nrises BCLK rises; the first is the delay bit when LRCLK changed.
    task automatic model_slot(input logic lr, input int nrises, input logic [DB-1:0] data);
        logic start;
        int   nd;
        start  = (lr != m_prev);
        m_prev = lr;
        nd     = nrises - 1;
        if (start) begin
            if (m_aligned && m_cnt < DB) begin
                m_serr    = 1'b1;
                m_left_ok = 1'b0;
            end
            m_cnt = 0;
            if (!lr) m_aligned = 1'b1;
            if (m_aligned) begin
                m_cnt = (nd < DB) ? nd : DB;
                if (nd >= DB) begin
                    if (!lr) begin
                        m_left    = data;
                        m_left_ok = 1'b1;
                    end else if (m_left_ok) begin
                        m_last    = {m_left, data};
                        m_left_ok = 1'b0;
                        if (m_full) m_ovf = 1'b1;
                        else exp_q.push_back({m_left, data});
                    end
                end
            end
        end
    endtask

    // Driver: falling edge changes LRCLK/SDATA, then the rising edge samples.
    task automatic drive_bit(input logic lr, input logic d);
        @(negedge clk);
        i_bclk  = 1'b0;
        i_lrclk = lr;
        i_sdata = d;
        repeat (half - 1) @(negedge clk);
        i_bclk = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input int nrises, input logic [DB-1:0] data, input logic tbit);
        logic d;
        model_slot(lr, nrises, data);
        for (int i = 0; i < nrises; i++) begin
            if (i == 0 || i > DB) d = tbit;
            else d = data[DB-i];
            drive_bit(lr, d);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] l, input logic [DB-1:0] r, input int nr, input logic tbit);
        send_slot(1'b0, nr, l, tbit);
        send_slot(1'b1, nr, r, tbit);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_aligned"},   FW'(o_aligned),    FW'(m_aligned));
        check({tag, "_overflow"},  FW'(o_overflow),   FW'(m_ovf));
        check({tag, "_slot_err"},  FW'(o_slot_error), FW'(m_serr));
        check({tag, "_frame_out"}, o_frame_out,       m_last);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        i_clear_errors = 1'b1;
        @(negedge clk);
        i_clear_errors = 1'b0;
        m_ovf  = 1'b0;
        m_serr = 1'b0;
    endtask

    task automatic bclk_low();
        @(negedge clk);
        i_bclk = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the next expected frame, one cycle wide, never while full.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_frame_valid === 1'b1) begin
                strobe_cyc.push_back(cyc);
                check("strobe_width", FW'(prev_valid), '0);
                check("valid_while_full", FW'(i_full), '0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=%h expected=none", o_frame_out);
                end else begin
                    check("frame_data", o_frame_out, exp_q.pop_front());
                end
            end
            prev_valid = o_frame_valid;
        end
    end

    initial begin
        int s0;
        logic [DB-1:0] l;
        logic [DB-1:0] r;
        reset = 1'b1;
        i_enable = 1'b1;
        i_bclk = 1'b0;
        i_lrclk = 1'b0;
        i_sdata = 1'b0;
        i_full = 1'b0;
        i_clear_errors = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_frame_out", o_frame_out, '0);
        check("reset_valid", FW'(o_frame_valid), '0);
        check_state("reset");

        // Alignment: start mid-left, 25 rises/slot, half period 25
        half = 25;
        send_slot(1'b0, 12, 24'hABCDEF, 1'b0);
        send_slot(1'b1, 25, 24'h123456, 1'b0);
        check_state("prealign");
        s0 = strobe_cyc.size();
        send_frame(24'hABCDEF, 24'h123456, 25, 1'b0);
        check("first_frame_lit", o_frame_out, 48'hABCDEF123456);
        check("first_aligned_lit", FW'(o_aligned), FW'(1));
        send_frame(24'hABCDEF, 24'h123456, 25, 1'b0);
        send_frame(24'hABCDEF, 24'h123456, 25, 1'b0);
        check_state("align");
        check("align_strobes", FW'(strobe_cyc.size() - s0), FW'(3));
        if (strobe_cyc.size() >= s0 + 3) begin
            check("spacing_1", FW'(strobe_cyc[s0+1] - strobe_cyc[s0]), FW'(2500));
            check("spacing_2", FW'(strobe_cyc[s0+2] - strobe_cyc[s0+1]), FW'(2500));
        end

        // Overflow: full held across one emit
        half = 8;
        send_slot(1'b0, 25, 24'h111111, 1'b0);
        @(negedge clk);
        i_full = 1'b1;
        m_full = 1'b1;
        send_slot(1'b1, 25, 24'h222222, 1'b0);
        i_full = 1'b0;
        m_full = 1'b0;
        check_state("ovf");
        check("ovf_frame_lit", o_frame_out, 48'h111111222222);
        check("ovf_flag_lit", FW'(o_overflow), FW'(1));
        pulse_clear();
        check("ovf_cleared", FW'(o_overflow), '0);
        send_frame(24'h333333, 24'h444444, 25, 1'b0);
        check_state("post_ovf");

        // Short right slot (20 data bits)
        send_slot(1'b0, 25, 24'h5A5A5A, 1'b0);
        send_slot(1'b1, 21, 24'hA5A5A5, 1'b0);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 25, 1'b0);
        check_state("short");
        check("short_err_lit", FW'(o_slot_error), FW'(1));
        pulse_clear();
        check("short_cleared", FW'(o_slot_error), '0);

        // Long slots, trailing ones
        send_frame(24'h800001, 24'h7FFFFE, 33, 1'b1);
        check("long_frame_lit", o_frame_out, 48'h8000017FFFFE);
        check_state("long");

        // Reset during a right slot
        send_slot(1'b0, 25, 24'hC0FFEE, 1'b0);
        send_slot(1'b1, 11, 24'hBADBAD, 1'b0);
        bclk_low();
        reset = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_frame_out", o_frame_out, '0);
        check_state("midrst");
        s0 = strobe_cyc.size();
        send_slot(1'b1, 25, 24'h000000, 1'b0);
        send_frame(24'h13579B, 24'h2468AC, 25, 1'b0);
        check("rst_strobes", FW'(strobe_cyc.size() - s0), FW'(1));
        check_state("post_rst");

        // Enable dropped during a left slot
        send_slot(1'b0, 11, 24'hDEAD00, 1'b0);
        bclk_low();
        i_enable = 1'b0;
        m_aligned = 1'b0;
        m_left_ok = 1'b0;
        m_prev = 1'b0;
        m_cnt = 0;
        repeat (20) @(negedge clk);
        check_state("disabled");
        i_enable = 1'b1;
        s0 = strobe_cyc.size();
        send_slot(1'b0, 15, 24'hDEAD00, 1'b0);
        send_slot(1'b1, 25, 24'hBEEF00, 1'b0);
        check("en_no_strobe", FW'(strobe_cyc.size() - s0), '0);
        send_frame(24'h0A0B0C, 24'h0D0E0F, 25, 1'b0);
        check("en_strobes", FW'(strobe_cyc.size() - s0), FW'(1));
        check_state("post_en");

        // Back-to-back incrementing frames
        s0 = strobe_cyc.size();
        for (int n = 0; n < 16; n++) begin
            l = DB'(n);
            r = ~l;
            send_frame(l, r, 25, 1'b0);
        end
        check("b2b_strobes", FW'(strobe_cyc.size() - s0), FW'(16));
        check_state("b2b");

        // Randomized frames: data, slot length, trailing bit value, bit rate
        for (int n = 0; n < 6; n++) begin
            half = $urandom_range(5, 10);
            l = DB'($urandom);
            r = DB'($urandom);
            send_frame(l, r, $urandom_range(25, 28), 1'($urandom_range(0, 1)));
            check_state("rand");
        end

        repeat (50) @(negedge clk);
        check("queue_empty", FW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- I2S slave receiver; the receive-side counterpart of the team's I2S master transmitter.
- Takes external BCLK/LRCLK/SDATA, oversamples them in the clk domain, and deserializes each stereo frame into one 48-bit word {left[23:0], right[23:0]}.
- Delivers each complete frame as a single-cycle write strobe to a downstream FIFO, using the same write/full convention as the transmitter's frame FIFO.

Parameters:
DATA_BITS, 24, sample width per channel; frame_out is 2*DATA_BITS wide.
SYNC_STAGES, 2, flip-flop stages on each async input (bclk, lrclk, sdata); minimum 2.

Ports:
clk  in  1  system clock (120 MHz nominal).
reset  in  1  synchronous, active-high.
enable  in  1  receiver enable; low holds the receive logic idle.
bclk  in  1  external bit clock, asynchronous to clk.
lrclk  in  1  external word select; 0 = left, 1 = right.
sdata  in  1  serial data, MSB first.
full  in  1  downstream FIFO full.
clear_errors  in  1  single-cycle pulse; clears the sticky flags.
frame_out  out  2*DATA_BITS  last received frame, left in upper half.
frame_valid  out  1  one-cycle write strobe to downstream FIFO.
aligned  out  1  high once a left-slot start has been seen.
overflow  out  1  sticky; a frame was dropped because full was high.
slot_error  out  1  sticky; a slot ended with fewer than DATA_BITS bits.

Behaviour:
- Reset values: frame_out=0, frame_valid=0, aligned=0, overflow=0, slot_error=0. Internal state also clears: bit_cnt=0, left_ok=0, lr_prev=0, shift register=0, synchronizers=0.
- Input synchronization: bclk, lrclk and sdata each pass through SYNC_STAGES flops, giving bclk_s, lrclk_s, sdata_s. bclk_d is bclk_s delayed one clk; rise = bclk_s & !bclk_d.
- bclk high and low phases must each be at least 4 clk; the transmitter uses 25.
- Line format, identical to the transmitter:
  - LRCLK changes on a BCLK falling edge, one bit before the MSB.
  - Data changes on falling edges and is sampled on rising edges.
  - Each slot is 1 delay bit followed by DATA_BITS data bits, then optional trailing bits (the transmitter sends 1 padding bit, so 25 rises per slot).
- Actions on each rise, when enable=1:
  - Always: lr_prev <= lrclk_s.
  - Slot start (lrclk_s != lr_prev): this rise is the delay bit and no data is captured. If aligned=1 and bit_cnt<DATA_BITS, set slot_error and clear left_ok. Then bit_cnt <= 0. If lrclk_s=0, set aligned=1.
  - Otherwise, if aligned=1 and bit_cnt<DATA_BITS: shift = {shift[DATA_BITS-2:0], sdata_s}; bit_cnt++.
  - Trailing bits (bit_cnt==DATA_BITS) are ignored; the count saturates.
- Channel complete, i.e. the rise that captures bit DATA_BITS:
  - lrclk_s=0: left_hold <= word; left_ok <= 1.
  - lrclk_s=1 and left_ok=1: emit {left_hold, word}; left_ok <= 0.
  - lrclk_s=1 and left_ok=0: discard the word.
- Emit timing:
  - If the completing rise is detected in cycle N, frame_out is updated and frame_valid=1 in cycle N+1 only, provided full=0 in cycle N+1.
  - If full=1 in cycle N+1: frame_valid stays 0, frame_out is still updated, and overflow is set.
- Sticky flags:
  - Cleared by reset or by clear_errors.
  - If a set condition coincides with clear_errors, the set wins.
- enable=0:
  - Clears aligned, bit_cnt, left_ok and frame_valid, and sets lr_prev=0.
  - Synchronizers keep running; sticky flags and frame_out hold.
  - On re-enable, capture begins only after the next lrclk 1->0 slot start.
- Alignment after reset or enable:
  - The first frame is emitted only after a complete left slot plus a complete right slot.
  - A left slot that is already in progress is never captured.
- Reset mid-frame: all state returns to reset values; the partial frame is lost and no strobe is generated.

Test Plan:
- Alignment and data: drive the transmitter-format stream (half period 25 clk, 25 rises/slot) with left=0xABCDEF, right=0x123456, starting mid-left-slot. Expect aligned=1 at the first left start and a first frame_valid carrying frame_out=0xABCDEF123456. Subsequent strobes are spaced exactly 2500 clk apart and each is one cycle wide.
- Overflow: hold full=1 across one emit. Expect no frame_valid for that frame, overflow=1 and frame_out updated. Then pulse clear_errors and expect overflow=0; the next frame strobes normally.
- Short slot: toggle lrclk after 20 data bits of a right slot. Expect slot_error=1, no frame for that stereo pair, and the following complete frame emitted correctly.
- Long slots: 33 rises per slot with trailing bits 0xFF. Expect only the top 24 bits captured, e.g. frame_out=0x800001_7FFFFE, and slot_error=0.
- Reset/enable mid-frame: assert reset during a right slot. Expect all outputs 0 and no strobe. Repeat with enable=0 during a left slot: the next frame is emitted only after a new 1->0 slot start.
- Back-to-back: 16 consecutive frames with incrementing values (left=n, right=~n). Expect 16 strobes in order, with no overflow or slot_error.
